// File: rtl/calc_pkg.sv
// calc_pkg -- shared types and helpers for the calculator display path.
//   num_t        : display number (sign, error, exponent, BCD significand)
//   bcd_t        : one BCD digit
//   NumDigits    : digits on the display (index 0 is the rightmost)
//   bcd2segments : BCD -> 7-segment pattern, {a,b,c,d,e,f,g} in bits 6..0
//   digit_blank  : leading-zero suppression predicate for one digit
package calc_pkg;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned ExpW      = $clog2(NumDigits);

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic                       sign;
    logic                       error;
    logic [ExpW-1:0]            exponent;     // digit index carrying the decimal point
    bcd_t [NumDigits-1:0]       significand;
  } num_t;

  // Active-high segments, a in bit 6 down to g in bit 0. Codes 10..15 are
  // not valid BCD; they fall back to the "9" glyph.
  function automatic logic [6:0] bcd2segments(input bcd_t d);
    logic [6:0] seg;
    unique case (d)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      default: seg = 7'b1111011;
    endcase
    return seg;
  endfunction

  // A digit is blank when it sits left of the decimal point and it and every
  // digit to its left are zero. Digit 0 always shows, so zero reads as "0".
  function automatic logic digit_blank(input bcd_t [NumDigits-1:0] sig,
                                       input logic [ExpW-1:0]      expo,
                                       input logic [ExpW-1:0]      idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NumDigits; i++) begin
      if (i >= int'(idx) && sig[i] != 4'd0) upper_zero = 1'b0;
    end
    return (idx != '0) && (idx > expo) && upper_zero;
  endfunction

endpackage

// File: rtl/calc_display_scan_if.sv
// calc_display_scan_if -- control and display bundle of calc_display_scan.
//   enable_i   : scan enable (low blanks and freezes the scan)
//   load_i     : one-cycle strobe capturing num_i into the shadow
//   num_i      : number to display
//   anode_o    : one-hot digit select, bit 0 rightmost
//   segments_o : segment pattern of the active digit
//   dp_o       : decimal point of the active digit
//   neg_o/err_o: sign / error indicators of the shadow
// master = driver of the display (host), slave = calc_display_scan.
interface calc_display_scan_if;
  import calc_pkg::*;

  logic                 enable_i;
  logic                 load_i;
  num_t                 num_i;
  logic [NumDigits-1:0] anode_o;
  logic [6:0]           segments_o;
  logic                 dp_o;
  logic                 neg_o;
  logic                 err_o;

  modport master (
    output enable_i, load_i, num_i,
    input  anode_o, segments_o, dp_o, neg_o, err_o
  );

  modport slave (
    input  enable_i, load_i, num_i,
    output anode_o, segments_o, dp_o, neg_o, err_o
  );
endinterface

// File: rtl/calc_tick_gen.sv
// calc_tick_gen -- refresh divider for the digit scan.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   en_i   : count enable; counter holds while low
//   tick_o : one-cycle pulse on the edge where the counter wraps to 0
module calc_tick_gen #(
  parameter int unsigned RefreshCycles = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned     CntW   = $clog2(RefreshCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(RefreshCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/calc_display_scan.sv
// calc_display_scan -- multiplexed 7-segment scanner for a calculator number.
//   clk_i  : clock, all state on the rising edge
//   rst_ni : synchronous active-low reset
//   bus    : calc_display_scan_if.slave (enable/load/num in, display out)
// The number is captured into a shadow on load_i; one digit is driven at a
// time for RefreshCycles clocks. All outputs are registered from the
// pre-edge index/shadow, so they trail the index by one cycle.
module calc_display_scan
  import calc_pkg::*;
#(
  parameter int unsigned RefreshCycles = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  calc_display_scan_if.slave    bus
);
  localparam logic [ExpW-1:0] IdxMax = ExpW'(NumDigits - 1);

  logic                 tick;
  logic [ExpW-1:0]      idx_q, idx_d;
  num_t                 shadow_q, shadow_d;
  logic [NumDigits-1:0] anode_q, anode_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 neg_q, err_q;
  logic                 blank;

  calc_tick_gen #(.RefreshCycles(RefreshCycles)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (bus.enable_i),
    .tick_o (tick)
  );

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    shadow_d = bus.load_i ? bus.num_i : shadow_q;
  end

  // Error overrides leading-zero suppression and blanks every digit.
  always_comb begin
    blank   = shadow_q.error ||
              digit_blank(shadow_q.significand, shadow_q.exponent, idx_q);
    anode_d = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    if (bus.enable_i) begin
      anode_d[idx_q] = 1'b1;
      if (!blank) seg_d = bcd2segments(shadow_q.significand[idx_q]);
      dp_d = !shadow_q.error && (idx_q == shadow_q.exponent) &&
             (shadow_q.exponent != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q    <= '0;
      shadow_q <= '0;
      anode_q  <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      neg_q    <= shadow_q.sign;
      err_q    <= shadow_q.error;
    end
  end

  assign bus.anode_o    = anode_q;
  assign bus.segments_o = seg_q;
  assign bus.dp_o       = dp_q;
  assign bus.neg_o      = neg_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_calc_display_scan.sv
// tb_calc_display_scan -- randomized self-checking bench for calc_display_scan
// with RefreshCycles=4. The reference model tracks the number of enabled
// cycles since reset and the captured number, and derives the active digit
// and its glyph arithmetically.
module tb_calc_display_scan;
  import calc_pkg::*;

  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en, load;
  num_t num;

  always #5 clk = ~clk;

  calc_display_scan_if bus();
  assign bus.enable_i = en;
  assign bus.load_i   = load;
  assign bus.num_i    = num;

  calc_display_scan #(.RefreshCycles(R)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          n;       // enabled edges since reset
  logic [31:0] m_sig;
  int          m_exp;
  bit          m_sign, m_err;

  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_neg, e_err;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  // Predict the outputs of the next edge from the pre-edge model, advance the
  // clock, sample #1 after the edge, then update the model.
  task automatic step();
    int idx, d;
    bit blank;
    if (!rst_n) begin
      e_an = '0; e_seg = '0; e_dp = 0; e_neg = 0; e_err = 0;
    end else if (!en) begin
      e_an = '0; e_seg = '0; e_dp = 0; e_neg = m_sign; e_err = m_err;
    end else begin
      idx   = (n / R) % 8;
      d     = int'((m_sig >> (4 * idx)) & 32'hF);
      blank = m_err || (idx > 0 && idx > m_exp && (m_sig >> (4 * idx)) == 0);
      e_an  = 8'(1 << idx);
      e_seg = blank ? 7'b0 : seg_tab[d > 9 ? 9 : d];
      e_dp  = !m_err && idx == m_exp && m_exp != 0;
      e_neg = m_sign;
      e_err = m_err;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n = 0; m_sig = 0; m_exp = 0; m_sign = 0; m_err = 0;
    end else begin
      if (en) n++;
      if (load) begin
        m_sig  = 32'(num.significand);
        m_exp  = int'(num.exponent);
        m_sign = num.sign;
        m_err  = num.error;
      end
    end
  endtask

  function automatic num_t mk(input logic [31:0] sig, input int ex,
                              input bit sg, input bit er);
    num_t r;
    r.significand = sig;
    r.exponent    = 3'(ex);
    r.sign        = sg;
    r.error       = er;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 0; en = 1; load = 1; num = mk(32'h87654321, 5, 1, 1);
    repeat (3) begin
      step();
      checks++;
      if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !== 17'b0) begin
        errors++;
        $display("FAIL reset got %h exp 0", {bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o});
      end
    end
    load = 0; rst_n = 1;
    step();
    checks++;
    if (bus.anode_o !== 8'h01 || bus.segments_o !== 7'b1111110) begin
      errors++;
      $display("FAIL reset_release got an=%h seg=%b exp an=01 seg=1111110", bus.anode_o, bus.segments_o);
    end
  endtask

  task automatic test_scan_blank();
    int holds = 0;
    for (int k = 0; k < 9 * R; k++) begin
      step();
      checks++;
      if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !==
          {e_an, e_seg, e_dp, e_neg, e_err}) begin
        errors++;
        $display("FAIL scan_blank k=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 k, bus.anode_o, bus.segments_o, bus.dp_o, e_an, e_seg, e_dp);
      end
      if (bus.anode_o == 8'h80) holds++;
    end
    checks++;
    if (holds !== R) begin
      errors++;
      $display("FAIL digit7_hold got %0d cycles exp %0d", holds, R);
    end
  endtask

  task automatic test_loads();
    num_t vec [3];
    vec[0] = mk(32'h00001234, 2, 1, 0);
    vec[1] = mk(32'h00000005, 3, 0, 0);
    vec[2] = mk(32'h12345678, 0, 0, 1);
    for (int v = 0; v < 3; v++) begin
      load = 1; num = vec[v];
      step();
      load = 0; num = mk($urandom, 1, 1, 1);
      step();
      checks++;
      if (bus.neg_o !== vec[v].sign || bus.err_o !== vec[v].error) begin
        errors++;
        $display("FAIL load_latency v=%0d got neg=%b err=%b exp neg=%b err=%b",
                 v, bus.neg_o, bus.err_o, vec[v].sign, vec[v].error);
      end
      for (int k = 0; k < 8 * R; k++) begin
        step();
        checks++;
        if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !==
            {e_an, e_seg, e_dp, e_neg, e_err}) begin
          errors++;
          $display("FAIL load v=%0d k=%0d got an=%h seg=%b dp=%b neg=%b err=%b exp an=%h seg=%b dp=%b neg=%b err=%b",
                   v, k, bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o,
                   e_an, e_seg, e_dp, e_neg, e_err);
        end
      end
    end
  endtask

  task automatic test_enable_pause();
    load = 1; num = mk(32'h00654321, 3, 0, 0);
    step();
    load = 0;
    for (int k = 0; k < 200 && (n % (8 * R)) != 5 * R + 1; k++) step();
    checks++;
    if ((n % (8 * R)) != 5 * R + 1) begin
      errors++;
      $display("FAIL pause_reach got n=%0d exp n%%%0d=%0d", n, 8 * R, 5 * R + 1);
    end
    en = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !==
          {e_an, e_seg, e_dp, e_neg, e_err}) begin
        errors++;
        $display("FAIL pause k=%0d got an=%h seg=%b dp=%b exp 0", k, bus.anode_o, bus.segments_o, bus.dp_o);
      end
    end
    en = 1;
    for (int k = 0; k < R; k++) begin
      step();
      checks++;
      if (bus.anode_o !== (k < R - 1 ? 8'h20 : 8'h40) || bus.segments_o !== e_seg) begin
        errors++;
        $display("FAIL resume k=%0d got an=%h seg=%b exp an=%h seg=%b",
                 k, bus.anode_o, bus.segments_o, k < R - 1 ? 8'h20 : 8'h40, e_seg);
      end
    end
  endtask

  task automatic test_load_wrap_reset();
    for (int k = 0; k < 2 * R && (n % R) != R - 2; k++) step();
    load = 1; num = mk(32'h00009999, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      load = 0;
      checks++;
      if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !==
          {e_an, e_seg, e_dp, e_neg, e_err}) begin
        errors++;
        $display("FAIL load_wrap k=%0d got an=%h seg=%b neg=%b exp an=%h seg=%b neg=%b",
                 k, bus.anode_o, bus.segments_o, bus.neg_o, e_an, e_seg, e_neg);
      end
    end
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    checks++;
    if (bus.anode_o !== 8'h01 || bus.segments_o !== 7'b1111110 || bus.neg_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got an=%h seg=%b neg=%b exp an=01 seg=1111110 neg=0",
               bus.anode_o, bus.segments_o, bus.neg_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] sig;
    int nz;
    for (int k = 0; k < 1500; k++) begin
      en    = ($urandom_range(0, 7) != 0);
      load  = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      nz    = $urandom_range(0, 8);
      sig   = (nz == 8) ? 32'h0 : ($urandom >> (4 * nz));
      num   = mk(sig, $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7) == 0);
      step();
      checks++;
      if ({bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o} !==
          {e_an, e_seg, e_dp, e_neg, e_err}) begin
        errors++;
        $display("FAIL random k=%0d got an=%h seg=%b dp=%b neg=%b err=%b exp an=%h seg=%b dp=%b neg=%b err=%b",
                 k, bus.anode_o, bus.segments_o, bus.dp_o, bus.neg_o, bus.err_o,
                 e_an, e_seg, e_dp, e_neg, e_err);
      end
    end
    rst_n = 1; load = 0; en = 1;
  endtask

  initial begin
    n = 0; m_sig = 0; m_exp = 0; m_sign = 0; m_err = 0;
    rst_n = 0; en = 0; load = 0; num = '0;
    test_reset();
    test_scan_blank();
    test_loads();
    test_enable_pause();
    test_load_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_display_scan.md
CALC_DISPLAY_SCAN -- requirements
Module: calc_display_scan

Interface
REQ-001 Parameter RefreshCycles, default 1000: clock cycles each digit is held active; legal range 2..65535.
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; one clock; synchronous, active-low.
REQ-004 enable_i  input  1  scan enable; low blanks the display and freezes scan state.
REQ-005 load_i  input  1  single-cycle strobe; captures num_i into the shadow register.
REQ-006 num_i  input  calc_pkg::num_t  number to display (sign, error, exponent, significand).
REQ-007 anode_o  output  calc_pkg::NumDigits  one-hot active-high digit select; bit 0 is the rightmost digit.
REQ-008 segments_o  output  7  segment pattern for the active digit, bit order per calc_pkg::bcd2segments.
REQ-009 dp_o  output  1  decimal-point segment for the active digit.
REQ-010 neg_o  output  1  minus indicator, equal to the shadow sign.
REQ-011 err_o  output  1  error indicator, equal to the shadow error.

Function
REQ-012 Shadow register: when load_i=1 on an edge, it takes num_i; otherwise it holds; scanning always uses the shadow, never num_i directly.
REQ-013 Load latency: a captured value appears on the outputs starting the second edge after the load edge; the scan index and refresh counter are not disturbed by load_i.
REQ-014 Refresh counter: counts 0..RefreshCycles-1 while enable_i=1, then wraps to 0; on the wrap edge the digit index advances.
REQ-015 Digit index: 0..NumDigits-1, increments by 1, wraps NumDigits-1 -> 0.
REQ-016 While enable_i=0: counter and index hold; anode_o, segments_o and dp_o are registered to 0; neg_o and err_o still track the shadow.
REQ-017 Digit i blank when i > exponent and significand digits i..NumDigits-1 are all 0; a blank digit keeps its anode bit, drives segments_o=0 and dp_o=0.
REQ-018 Digit 0 is never blanked; an all-zero significand with exponent 0 shows a single "0".
REQ-019 dp_o=1 only when the active index equals exponent and exponent != 0.
REQ-020 Non-blank segments_o = calc_pkg::bcd2segments(significand[index]); BCD codes 10..15 display as 9.
REQ-021 err_o=1 forces every digit blank, including digit 0, and dp_o=0; anode scanning continues.
REQ-022 Outputs are registered: they reflect the index, counter and shadow state present before the same edge, so each output is one cycle behind the index.

Reset
REQ-023 rst_ni=0 on an edge clears the shadow to all-zero, the counter to 0 and the index to 0, and registers all outputs to 0.
REQ-024 Reset mid-scan or mid-load discards the in-flight load; the first edge after release with enable_i=1 drives anode_o=1 (digit 0) and segments_o=7'b1111110.

Structure
REQ-025 num_t, bcd_t, NumDigits and bcd2segments are used from calc_pkg; the blanking predicate goes into calc_pkg as a function (significand, exponent, index -> blank); no new typedefs.
REQ-026 One sub-module, calc_tick_gen (parameter RefreshCycles; ports clk_i, rst_ni, en_i, tick_o), produces the one-cycle wrap tick; the index, shadow and output registers stay in calc_display_scan.

Verification (RefreshCycles=4)
REQ-027 Reset, enable_i=1, no load -> anode_o cycles 0x01,0x02,...,0x80,0x01, each held exactly 4 cycles; only digit 0 shows 7'b1111110; all other digits show 0.
REQ-028 Load significand 0x00001234, exponent 2, sign 1 -> digits 3..0 show 1,2,3,4; dp_o=1 only on digit 2; digits 7..4 blank; neg_o=1.
REQ-029 Load significand 0x00000005, exponent 3 -> digits 3..0 show 0,0,0,5 (leading zeros kept up to exponent); dp_o on digit 3.
REQ-030 Load error=1, significand 0x12345678 -> err_o=1; all segments_o=0; anode still scans.
REQ-031 enable_i low for 10 cycles during digit 5 -> outputs all 0; when re-enabled, scanning resumes on digit 5 with its remaining count intact.
REQ-032 Pulse load_i one cycle before a wrap tick, then assert rst_ni=0 -> scan timing unaffected by the load; after reset, the shadow is zero and output restarts at digit 0.
